// File: rtl/req_ack_master.sv
// rtl/req_ack_master.sv - queued req/ack master with per-attempt timeout and bounded retry
// Optional statistics counters: define REQ_ACK_MASTER_STATS_EN.
module req_ack_master #(
  parameter int ID_W      = 4,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [ID_W-1:0] cmd_id,
  output logic            req,
  input  logic            ack,
  output logic            rsp_valid,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_err,
  output logic            busy
`ifdef REQ_ACK_MASTER_STATS_EN
  ,
  output logic [15:0]     ok_cnt,
  output logic [15:0]     err_cnt,
  output logic [15:0]     spur_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_GAP,
    S_RSP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0] mem_q [DEPTH];
  logic            req_q, rsp_valid_q, rsp_err_q;
  logic [ID_W-1:0] rsp_id_q;
  logic            full, empty, push, pop, fail_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_RSP);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_id;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    fail_d  = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_REQ;
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ack wins over a timeout landing in the same cycle.
        if (ack) begin
          state_d = S_RSP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_GAP;
          end else begin
            fail_d  = 1'b1;
            state_d = S_RSP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_GAP: state_d = S_REQ;
      S_RSP: begin
        retry_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      req_q       <= (state_d == S_REQ);
      rsp_valid_q <= (state_d == S_RSP);
      rsp_err_q   <= (state_d == S_RSP) && fail_d;
      if (state_d == S_RSP) rsp_id_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign req       = req_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != S_IDLE) || !empty;

`ifdef REQ_ACK_MASTER_STATS_EN
  logic [15:0] ok_cnt_q, err_cnt_q, spur_cnt_q;
  logic        spur;

  assign spur = ack && (state_q != S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
      spur_cnt_q <= '0;
    end else begin
      if (rsp_valid_q && !rsp_err_q && ok_cnt_q != 16'hFFFF)  ok_cnt_q   <= ok_cnt_q + 1'b1;
      if (rsp_valid_q && rsp_err_q && err_cnt_q != 16'hFFFF)  err_cnt_q  <= err_cnt_q + 1'b1;
      if (spur && spur_cnt_q != 16'hFFFF)                     spur_cnt_q <= spur_cnt_q + 1'b1;
    end
  end

  assign ok_cnt   = ok_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign spur_cnt = spur_cnt_q;
`endif

endmodule

// File: tb/tb_req_ack_master.sv
// tb/tb_req_ack_master.sv - directed vector bench for req_ack_master
module tb_req_ack_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_id;
  logic       req;
  logic       ack;
  logic       rsp_valid;
  logic [3:0] rsp_id;
  logic       rsp_err;
  logic       busy;
`ifdef REQ_ACK_MASTER_STATS_EN
  logic [15:0] ok_cnt, err_cnt, spur_cnt;
`endif

  req_ack_master #(.ID_W(4), .DEPTH(4), .TIMEOUT(8), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .req       (req),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef REQ_ACK_MASTER_STATS_EN
    ,
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt),
    .spur_cnt  (spur_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Responder/monitor state, updated on the falling edge.
  int cyc        = 0;
  int ack_at     = -1;
  int ack_dly    = 1;
  int fail_left  = 0;
  int stray_ack  = 0;
  int pulses     = 0;
  int rsp_seen   = 0;
  int rsp_cyc    = 0;
  logic prev_req = 1'b0;
  int   req_cycs[$];
  int   rsp_ids[$];
  int   rsp_errs[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      ack = (ack_at == cyc) || (stray_ack != 0);
      if (req) begin
        check("req_not_consecutive", int'(prev_req), 0);
        pulses++;
        req_cycs.push_back(cyc);
        if (fail_left > 0) fail_left--;
        else ack_at = cyc + ack_dly;
      end
      prev_req = req;
      if (rsp_valid) begin
        rsp_seen++;
        rsp_cyc = cyc;
        rsp_ids.push_back(int'(rsp_id));
        rsp_errs.push_back(int'(rsp_err));
      end
    end
  end

  typedef struct {
    logic [3:0] id;
    int         fail_n;
    int         dly;
    int         exp_pulses;
    int         exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];
  int   exp_ok  = 0;
  int   exp_errc = 0;

  task automatic clear_mon(input int f, input int d);
    pulses    = 0;
    rsp_seen  = 0;
    fail_left = f;
    ack_dly   = d;
    req_cycs.delete();
    rsp_ids.delete();
    rsp_errs.delete();
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rsp_seen < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (rsp_seen < n) check({name, "_timeout"}, rsp_seen, n);
  endtask

  task automatic check_stats();
`ifdef REQ_ACK_MASTER_STATS_EN
    check("ok_cnt", int'(ok_cnt), exp_ok);
    check("err_cnt", int'(err_cnt), exp_errc);
`endif
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int push_cyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    clear_mon(v.fail_n, v.dly);
    cmd_valid = 1'b1;
    cmd_id    = v.id;
    push_cyc  = cyc + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(1, 200, tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_rsp_count"}, rsp_seen, 1);
    check({tag, "_rsp_id"}, (rsp_ids.size() > 0) ? rsp_ids[0] : -1, int'(v.id));
    check({tag, "_rsp_err"}, (rsp_errs.size() > 0) ? rsp_errs[0] : -1, v.exp_err);
    check({tag, "_pulses"}, pulses, v.exp_pulses);
    if (req_cycs.size() > 0) begin
      check({tag, "_push_to_req"}, req_cycs[0] - push_cyc, 2);
      check({tag, "_latency"}, rsp_cyc - req_cycs[0], v.exp_lat);
      check({tag, "_retry_span"}, req_cycs[req_cycs.size()-1] - req_cycs[0], (v.exp_pulses - 1) * 10);
    end else begin
      check({tag, "_no_req"}, 0, 1);
    end
    check({tag, "_busy_idle"}, int'(busy), 0);
    if (v.exp_err != 0) exp_errc++;
    else exp_ok++;
    check_stats();
  endtask

  initial begin
    int first_ready;
    int k;
    int pre_rsp;
    int pre_pulses;

    vecs[0] = '{id: 4'd3,  fail_n: 0,  dly: 2, exp_pulses: 1, exp_err: 0, exp_lat: 3};
    vecs[1] = '{id: 4'd5,  fail_n: 99, dly: 2, exp_pulses: 3, exp_err: 1, exp_lat: 29};
    vecs[2] = '{id: 4'd9,  fail_n: 1,  dly: 2, exp_pulses: 2, exp_err: 0, exp_lat: 13};
    vecs[3] = '{id: 4'd10, fail_n: 0,  dly: 8, exp_pulses: 1, exp_err: 0, exp_lat: 9};
    vecs[4] = '{id: 4'd15, fail_n: 0,  dly: 1, exp_pulses: 1, exp_err: 0, exp_lat: 2};
    vecs[5] = '{id: 4'd6,  fail_n: 2,  dly: 3, exp_pulses: 3, exp_err: 0, exp_lat: 24};
    vecs[6] = '{id: 4'd12, fail_n: 1,  dly: 8, exp_pulses: 2, exp_err: 0, exp_lat: 19};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_id    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", int'(req), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_err", int'(rsp_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Five back-to-back pushes into a four-entry queue.
    @(posedge clk); #1;
    clear_mon(0, 1);
    first_ready = -1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_id    = 4'(i + 1);
      k = 0;
      forever begin
        logic r;
        @(negedge clk);
        r = cmd_ready;
        if (i == 4 && k == 0) first_ready = int'(r);
        @(posedge clk); #1;
        k++;
        if (r || k > 50) break;
      end
    end
    cmd_valid = 1'b0;
    check("fifo_full_ready", first_ready, 0);
    wait_rsp(5, 100, "fifo");
    repeat (3) @(posedge clk);
    #1;
    check("fifo_rsp_count", rsp_seen, 5);
    for (int i = 0; i < 5 && i < rsp_ids.size(); i++)
      check($sformatf("fifo_order%0d", i), rsp_ids[i], i + 1);
    for (int i = 1; i < 5 && i < req_cycs.size(); i++)
      check($sformatf("fifo_spacing%0d", i), req_cycs[i] - req_cycs[i-1], 4);
    exp_ok += 5;
    check_stats();

    // Reset during WAIT with further commands queued.
    @(posedge clk); #1;
    clear_mon(99, 1);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_id    = 4'(i + 7);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    k = 0;
    while (pulses < 1 && k < 20) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", int'(req), 0);
    check("mid_rst_rsp_valid", int'(rsp_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check("mid_rst_rsp_id", int'(rsp_id), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ok   = 0;
    exp_errc = 0;
    pre_rsp    = rsp_seen;
    pre_pulses = pulses;
    @(posedge clk); #1;
    stray_ack = 1;
    @(posedge clk); #1;
    stray_ack = 0;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_no_rsp", rsp_seen - pre_rsp, 0);
    check("post_rst_no_req", pulses - pre_pulses, 0);
    check("post_rst_busy", int'(busy), 0);
    check_stats();
`ifdef REQ_ACK_MASTER_STATS_EN
    check("spur_cnt", int'(spur_cnt), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
